// File: rtl/uart_tx_if.sv
// uart_tx_if: request/data and serial-side signals of the UART transmitter
interface uart_tx_if #(parameter int DBIT = 8);
  logic s_tick;
  logic tx_start;
  logic [DBIT-1:0] din;
  logic tx_busy;
  logic tx_done_tick;
  logic tx;
  modport master (output s_tick, tx_start, din, input tx_busy, tx_done_tick, tx);
  modport slave (input s_tick, tx_start, din, output tx_busy, tx_done_tick, tx);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 16x-tick driven UART serialiser, LSB first, optional parity, SB_TICK-long stop period
module uart_tx #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter bit PARITY_EN = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic clk,
  input logic rst,
  uart_tx_if.slave bus
);
  localparam int NW = $clog2(DBIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [4:0] s;
  logic [NW-1:0] n;
  logic [DBIT-1:0] b;
  logic p;
  logic tx_reg;
  assign bus.tx = tx_reg;
  assign bus.tx_busy = state != IDLE;
  assign bus.tx_done_tick = state == STOP && bus.s_tick && s == 5'(SB_TICK - 1);
  // tx_reg is loaded with the level of the state being entered so the pin changes on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      p <= 1'b0;
      tx_reg <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.tx_start) begin
          b <= bus.din;
          p <= ^bus.din ^ PARITY_ODD;
          s <= '0;
          state <= START;
          tx_reg <= 1'b0;
        end
        START: if (bus.s_tick) begin
          if (s == 5'd15) begin
            s <= '0;
            n <= '0;
            state <= DATA;
            tx_reg <= b[0];
          end else s <= s + 5'd1;
        end
        DATA: if (bus.s_tick) begin
          if (s == 5'd15) begin
            s <= '0;
            b <= b >> 1;
            if (n == NW'(DBIT - 1)) begin
              state <= PARITY_EN ? PARITY : STOP;
              tx_reg <= PARITY_EN ? p : 1'b1;
            end else begin
              n <= n + 1'b1;
              tx_reg <= b[1];
            end
          end else s <= s + 5'd1;
        end
        PARITY: if (bus.s_tick) begin
          if (s == 5'd15) begin
            s <= '0;
            state <= STOP;
            tx_reg <= 1'b1;
          end else s <= s + 5'd1;
        end
        STOP: if (bus.s_tick) begin
          if (s == 5'(SB_TICK - 1)) begin
            s <= '0;
            state <= IDLE;
          end else s <= s + 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
